// File: rtl/twos_pkg.sv
// rtl/twos_pkg.sv - shared encodings and sizing helper for the serial two's-complement unit
package twos_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_ONES = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // The digit counter has to reach n_digits itself, hence the +1.
    function automatic int cnt_width(input int n_digits);
        return (n_digits < 1) ? 1 : $clog2(n_digits + 1);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - DIGIT full_adder cells rippled together; b is tied low so it adds cin to a
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (1'b0),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/twos_complement_serial.sv
// rtl/twos_complement_serial.sv - digit-serial pass/negate/abs/ones'-complement unit
// with valid/ready handshakes on both sides and an overflow flag for the most-negative operand.
module twos_complement_serial
    import twos_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             ovf
);

    if ((DIGIT < 1) || (WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_param_check
        $error("twos_complement_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    localparam int               NDIG     = WIDTH / DIGIT;
    localparam int               CW       = cnt_width(NDIG);
    localparam logic [CW-1:0]    LAST     = CW'(NDIG);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             inv_q, inv_d;
    logic             cin0_q, cin0_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] add_a;
    logic [DIGIT-1:0] add_sum;
    logic             add_cin;
    logic             add_cout;

    // a_q is shifted right each RUN cycle, so the current digit is always its low slice.
    assign add_a   = a_q[DIGIT-1:0] ^ {DIGIT{inv_q}};
    assign add_cin = (count_q == '0) ? cin0_q : carry_q;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (add_a),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        inv_d       = inv_q;
        cin0_d      = cin0_q;
        carry_d     = carry_q;
        count_d     = count_q;
        y_d         = y_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = A;
                    inv_d      = (mode == MODE_NEG) || (mode == MODE_ONES) ||
                                 ((mode == MODE_ABS) && A[WIDTH-1]);
                    cin0_d     = inv_d && (mode != MODE_ONES);
                    ovf_d      = ((mode == MODE_NEG) || (mode == MODE_ABS)) && (A == MOST_NEG);
                    carry_d    = 1'b0;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // One extra RUN cycle at count==LAST gives the accept-to-valid latency of NDIG+1.
                if (count_q == LAST) begin
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    y_d[32'(count_q)*DIGIT +: DIGIT] = add_sum;
                    carry_d = add_cout;
                    a_d     = a_q >> DIGIT;
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            inv_q       <= 1'b0;
            cin0_q      <= 1'b0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            inv_q       <= inv_d;
            cin0_q      <= cin0_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign ovf       = ovf_q;

endmodule
